wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone B4 classic arbiter that shares one Wishbone slave among N Wishbone masters.
- Typical slave is the modexp_top RSA core behind its AXI4-Lite bridge, shared between the bridge and on-chip DMA/test masters.
- A grant is held for the whole cycle (cyc high), so multi-register accesses are atomic.
- An optional watchdog aborts a hung slave access.

Parameters:
- N_MASTERS, 4: number of requesting masters, 2..8.
- ADDR_W, 32: Wishbone address width.
- DATA_W, 32: Wishbone data width; sel width is DATA_W/8.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- m_adr_i  in  N_MASTERS*ADDR_W  master addresses, master k at slice k.
- m_dat_i  in  N_MASTERS*DATA_W  master write data.
- m_sel_i  in  N_MASTERS*DATA_W/8  master byte selects.
- m_we_i  in  N_MASTERS  master write enables.
- m_cyc_i  in  N_MASTERS  master cycle (request).
- m_stb_i  in  N_MASTERS  master strobes.
- m_dat_o  out  DATA_W  read data, broadcast to all masters.
- m_ack_o  out  N_MASTERS  per-master ack.
- m_err_o  out  N_MASTERS  per-master error.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_sel_o  out  DATA_W/8  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  DATA_W  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave error.
- grant_o  out  N_MASTERS  registered one-hot grant; all zero when idle.
- busy_o  out  1  high whenever a grant is held.

Behaviour:
- Reset (async, rst_i high):
  - grant_o = 0, busy_o = 0; last-winner pointer = N_MASTERS-1, so master 0 wins first.
  - All slave outputs and m_ack_o/m_err_o are 0; m_dat_o follows s_dat_i.
  - Reset mid-cycle drops s_cyc_o/s_stb_o immediately; the interrupted master gets no ack.
- States: IDLE (grant_o = 0) and OWN (exactly one grant bit set).
- IDLE -> OWN:
  - On any m_cyc_i bit, register grant for the first requester searched from (last+1) mod N upward, wrapping.
  - The slave sees the first strobe one cycle after the cyc request (1-cycle arbitration latency).
- OWN, owner g:
  - Combinationally: s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g] & m_cyc_i[g].
  - adr/dat/sel/we are muxed from slice g. Non-granted slices are ignored; the slave-side mux output while IDLE is don't-care, but cyc/stb are 0.
  - m_ack_o[g] = s_ack_i and m_err_o[g] = s_err_i; all other ack/err bits are 0.
  - Ack passes through with zero added latency; pipelined back-to-back strobes within one cyc are passed unchanged.
- Release (owner drops m_cyc_i[g]):
  - The same cycle, s_cyc_o goes low.
  - At the next edge, last = g. If another master requests, the grant hands off directly to the next round-robin requester (no idle gap); otherwise go to IDLE.
- A master re-asserting cyc right after release does not win over other pending requesters (fairness).
- If s_ack_i/s_err_i arrives when s_stb_o = 0 (stale), it is dropped and not forwarded.
- N_MASTERS = 1 degenerates to a registered pass-through with 1-cycle grant latency.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments on each cycle with s_stb_o high and neither s_ack_i nor s_err_i.
  - It clears on ack, err or release.
  - On reaching TIMEOUT_CYCLES: pulse m_err_o[g] for 1 cycle, force s_cyc_o/s_stb_o low that cycle, clear the counter. The grant is retained until the owner drops cyc.
- Undefined: no counter logic; a hung slave blocks the arbiter indefinitely.

Decomposition:
- Package wb_arb_pkg holds:
  - arb_state_e enum (IDLE, OWN);
  - localparam defaults (DEF_ADDR_W, DEF_DATA_W, DEF_TIMEOUT);
  - function rr_next(req, last) returning one-hot.
- One sub-module rr_pick: purely combinational rotate/priority-encode/unrotate. Inputs are the req vector and last index; outputs are the one-hot winner, winner index and any_req.

Test Plan (N_MASTERS = 4, DATA_W = 32):
- Single master: master 2 writes 0xDEADBEEF to 0x10, slave acks on the 2nd cycle → grant_o = 0100 one cycle after cyc; s_dat_o = 0xDEADBEEF, s_adr_o = 0x10; only m_ack_o[2] pulses.
- Fairness: masters 0, 1 and 3 hold cyc continuously, each releasing after one acked access → grant order 0, 1, 3, 0, 1, 3 with direct handoffs and no idle cycles.
- Atomic burst: master 1 holds cyc for 4 reads (slave returns 1, 2, 3, 4) while master 0 requests → master 0 is not granted until master 1 drops cyc; m_dat_o carries 1..4 with m_ack_o[1] only.
- Error routing: slave asserts s_err_i on master 3's access → m_err_o[3] = 1 for 1 cycle; all other m_err_o and m_ack_o bits stay 0.
- Reset mid-access: assert rst_i while master 0 is owner and the slave has not acked → s_cyc_o = 0 asynchronously, grant_o = 0. After release, a request from master 0 wins first.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, the slave never acks → m_err_o[g] pulses after exactly 16 stalled strobe cycles and s_stb_o is low that cycle. Without the macro, no err occurs after 100 cycles.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types, defaults and round-robin helper for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 1024;
    localparam int unsigned MAX_MASTERS = 8;

    // Unused upper request bits must be zero so the mod-8 search equals a mod-N search.
    function automatic logic [MAX_MASTERS-1:0] rr_next(input logic [MAX_MASTERS-1:0] req,
                                                       input logic [2:0]             last);
        logic [MAX_MASTERS-1:0] win;
        logic [2:0]             j;
        win = '0;
        for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
            j = 3'((32'(last) + i) % MAX_MASTERS);
            if (win == '0 && req[j]) win[j] = 1'b1;
        end
        return win;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate past the last winner, priority-encode, unrotate.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    logic [N-1:0]  rot;
    logic [IW-1:0] pos;
    logic          found;

    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rot[i] = req[IW'((i + 32'(last) + 1) % N)];
        end
        pos   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = IW'(i);
            end
        end
        idx    = IW'((32'(pos) + 32'(last) + 1) % N);
        onehot = '0;
        if (found) onehot[idx] = 1'b1;
    end

    assign any_req = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter; grant held for the whole master cycle.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS      = 4,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_adr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_dat_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_sel_i,
    input  logic [N_MASTERS-1:0]            m_we_i,
    input  logic [N_MASTERS-1:0]            m_cyc_i,
    input  logic [N_MASTERS-1:0]            m_stb_i,
    output logic [DATA_W-1:0]               m_dat_o,
    output logic [N_MASTERS-1:0]            m_ack_o,
    output logic [N_MASTERS-1:0]            m_err_o,
    output logic [ADDR_W-1:0]               s_adr_o,
    output logic [DATA_W-1:0]               s_dat_o,
    output logic [DATA_W/8-1:0]             s_sel_o,
    output logic                            s_we_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    input  logic [DATA_W-1:0]               s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    output logic [N_MASTERS-1:0]            grant_o,
    output logic                            busy_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned IW    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_q, last_d;

    logic [N_MASTERS-1:0] pick_onehot;
    logic [IW-1:0]        pick_idx, pick_last;
    logic                 pick_any;
    logic                 own, owner_cyc, fire;

    assign own       = (state_q == OWN);
    assign owner_cyc = m_cyc_i[gidx_q];

    // While owning, the only time the picker matters is the release cycle, when last becomes gidx.
    assign pick_last = own ? gidx_q : last_q;

    rr_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
        .req     (m_cyc_i),
        .last    (pick_last),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OWN;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                end
            end
            OWN: begin
                if (!owner_cyc) begin
                    last_d = gidx_q;
                    if (pick_any) begin
                        grant_d = pick_onehot;
                        gidx_d  = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;

    assign fire = own && owner_cyc && (tmo_q == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_q <= '0;
        else if (!own || !owner_cyc || fire || s_ack_i || s_err_i)
            tmo_q <= '0;
        else if (s_stb_o)
            tmo_q <= tmo_q + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign fire = 1'b0;
`endif

    assign s_cyc_o = own && owner_cyc && !fire;
    assign s_stb_o = own && owner_cyc && m_stb_i[gidx_q] && !fire;
    assign s_adr_o = own ? m_adr_i[gidx_q*ADDR_W +: ADDR_W] : '0;
    assign s_dat_o = own ? m_dat_i[gidx_q*DATA_W +: DATA_W] : '0;
    assign s_sel_o = own ? m_sel_i[gidx_q*SEL_W +: SEL_W] : '0;
    assign s_we_o  = own && m_we_i[gidx_q];

    // Responses only count while a strobe is actually presented; stale ones are swallowed.
    assign m_ack_o = (s_ack_i && s_stb_o) ? grant_q : '0;
    assign m_err_o = ((s_err_i && s_stb_o) || fire) ? grant_q : '0;
    assign m_dat_o = s_dat_i;

    assign grant_o = grant_q;
    assign busy_o  = own;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with four 32-bit masters.
module tb_wb_rr_arbiter;

    localparam int N = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat = '0;
    logic [N*4-1:0]  m_sel = '0;
    logic [N-1:0]    m_we = '0, m_cyc = '0, m_stb = '0;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [3:0]      s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o, busy_o;
    logic [DW-1:0]   s_dat = '0;
    logic            s_ack = 1'b0, s_err = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    wb_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                              input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[k] = cyc;
        m_stb[k] = stb;
        m_we[k]  = we;
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = dat;
        m_sel[k*4 +: 4]   = 4'hF;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_dat = 32'h1234_5678;
        set_master(0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h55);
        tick();
        #4;
        total_cnt++; if (grant_o !== 4'b0000) $display("FAIL reset_grant got=%b want=0000", grant_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy_o); else pass_cnt++;
        total_cnt++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) $display("FAIL reset_slave_ctl got=%b want=000", {s_cyc_o, s_stb_o, s_we_o}); else pass_cnt++;
        total_cnt++; if (s_adr_o !== 32'h0) $display("FAIL reset_adr got=%h want=0", s_adr_o); else pass_cnt++;
        total_cnt++; if ({m_ack_o, m_err_o} !== 8'h00) $display("FAIL reset_ack_err got=%b want=0", {m_ack_o, m_err_o}); else pass_cnt++;
        total_cnt++; if (m_dat_o !== 32'h1234_5678) $display("FAIL reset_dat got=%h want=12345678", m_dat_o); else pass_cnt++;
        set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_master(2, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        #4;
        total_cnt++; if ({grant_o, s_stb_o} !== 5'b0000_0) $display("FAIL single_latency got=%b want=00000", {grant_o, s_stb_o}); else pass_cnt++;
        tick();
        #4;
        total_cnt++; if (grant_o !== 4'b0100) $display("FAIL single_grant got=%b want=0100", grant_o); else pass_cnt++;
        total_cnt++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b111) $display("FAIL single_ctl got=%b want=111", {s_cyc_o, s_stb_o, s_we_o}); else pass_cnt++;
        total_cnt++; if (s_adr_o !== 32'h10) $display("FAIL single_adr got=%h want=10", s_adr_o); else pass_cnt++;
        total_cnt++; if (s_dat_o !== 32'hDEADBEEF) $display("FAIL single_dat got=%h want=deadbeef", s_dat_o); else pass_cnt++;
        total_cnt++; if (s_sel_o !== 4'hF) $display("FAIL single_sel got=%h want=f", s_sel_o); else pass_cnt++;
        total_cnt++; if (m_ack_o !== 4'b0000) $display("FAIL single_noack got=%b want=0000", m_ack_o); else pass_cnt++;
        tick();
        s_ack = 1'b1;
        #4;
        total_cnt++; if (m_ack_o !== 4'b0100) $display("FAIL single_ack got=%b want=0100", m_ack_o); else pass_cnt++;
        tick();
        s_ack = 1'b0;
        set_master(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        total_cnt++; if ({s_cyc_o, m_ack_o} !== 5'b0_0000) $display("FAIL single_release got=%b want=00000", {s_cyc_o, m_ack_o}); else pass_cnt++;
        tick();
        #4;
        total_cnt++; if ({grant_o, busy_o} !== 5'b0000_0) $display("FAIL single_idle got=%b want=00000", {grant_o, busy_o}); else pass_cnt++;
    endtask

    task automatic test_fairness();
        int order[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
        set_master(3, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            s_ack = 1'b1;
            #4;
            total_cnt++; if (grant_o !== 4'(1 << order[i])) $display("FAIL fair_grant[%0d] got=%b want=%b", i, grant_o, 4'(1 << order[i])); else pass_cnt++;
            total_cnt++; if (m_ack_o !== 4'(1 << order[i])) $display("FAIL fair_ack[%0d] got=%b want=%b", i, m_ack_o, 4'(1 << order[i])); else pass_cnt++;
            tick();
            s_ack = 1'b0;
            m_cyc[order[i]] = 1'b0;
            m_stb[order[i]] = 1'b0;
            #4;
            total_cnt++; if ({busy_o, s_cyc_o} !== 2'b10) $display("FAIL fair_release[%0d] got=%b want=10", i, {busy_o, s_cyc_o}); else pass_cnt++;
            tick();
            m_cyc[order[i]] = 1'b1;
            m_stb[order[i]] = 1'b1;
        end
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();
        #4;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL fair_idle got=%b want=0", busy_o); else pass_cnt++;
    endtask

    task automatic test_burst();
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        set_master(0, 1'b1, 1'b1, 1'b1, 32'h30, 32'h99);
        for (int n = 1; n <= 4; n++) begin
            s_ack = 1'b1;
            s_dat = 32'(n);
            #4;
            total_cnt++; if (grant_o !== 4'b0010) $display("FAIL burst_grant[%0d] got=%b want=0010", n, grant_o); else pass_cnt++;
            total_cnt++; if (m_ack_o !== 4'b0010) $display("FAIL burst_ack[%0d] got=%b want=0010", n, m_ack_o); else pass_cnt++;
            total_cnt++; if (m_dat_o !== 32'(n)) $display("FAIL burst_dat[%0d] got=%h want=%h", n, m_dat_o, 32'(n)); else pass_cnt++;
            total_cnt++; if ({s_adr_o, s_we_o} !== {32'h20, 1'b0}) $display("FAIL burst_adr[%0d] got=%h/%b want=20/0", n, s_adr_o, s_we_o); else pass_cnt++;
            tick();
        end
        s_ack = 1'b0;
        set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        total_cnt++; if ({grant_o, s_cyc_o} !== 5'b0010_0) $display("FAIL burst_release got=%b want=00100", {grant_o, s_cyc_o}); else pass_cnt++;
        tick();
        #4;
        total_cnt++; if ({grant_o, s_adr_o} !== {4'b0001, 32'h30}) $display("FAIL burst_handoff got=%b/%h want=0001/30", grant_o, s_adr_o); else pass_cnt++;
        set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
    endtask

    task automatic test_error();
        set_master(3, 1'b1, 1'b0, 1'b0, 32'h3C, 32'h0);
        tick();
        s_ack = 1'b1;
        #4;
        total_cnt++; if ({grant_o, s_stb_o} !== 5'b1000_0) $display("FAIL err_owner got=%b want=10000", {grant_o, s_stb_o}); else pass_cnt++;
        total_cnt++; if (m_ack_o !== 4'b0000) $display("FAIL err_stale_ack got=%b want=0000", m_ack_o); else pass_cnt++;
        tick();
        s_ack = 1'b0;
        s_err = 1'b1;
        m_stb[3] = 1'b1;
        #4;
        total_cnt++; if (m_err_o !== 4'b1000) $display("FAIL err_route got=%b want=1000", m_err_o); else pass_cnt++;
        total_cnt++; if (m_ack_o !== 4'b0000) $display("FAIL err_noack got=%b want=0000", m_ack_o); else pass_cnt++;
        tick();
        s_err = 1'b0;
        set_master(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        total_cnt++; if (m_err_o !== 4'b0000) $display("FAIL err_pulse got=%b want=0000", m_err_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        set_master(0, 1'b1, 1'b1, 1'b1, 32'h50, 32'h77);
        tick();
        #1;
        total_cnt++; if ({grant_o, s_cyc_o} !== 5'b0001_1) $display("FAIL rmid_owner got=%b want=00011", {grant_o, s_cyc_o}); else pass_cnt++;
        #1;
        rst = 1'b1;
        #1;
        total_cnt++; if ({s_cyc_o, s_stb_o} !== 2'b00) $display("FAIL rmid_async_cyc got=%b want=00", {s_cyc_o, s_stb_o}); else pass_cnt++;
        total_cnt++; if ({grant_o, m_ack_o} !== 8'h00) $display("FAIL rmid_grant got=%b want=0", {grant_o, m_ack_o}); else pass_cnt++;
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        #4;
        total_cnt++; if (grant_o !== 4'b0001) $display("FAIL rmid_first got=%b want=0001", grant_o); else pass_cnt++;
        set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
    endtask

    task automatic test_timeout();
        set_master(2, 1'b1, 1'b1, 1'b0, 32'h70, 32'h0);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            #4;
            total_cnt++; if ({s_stb_o, m_err_o} !== 5'b1_0000) $display("FAIL tmo_stall[%0d] got=%b want=10000", i, {s_stb_o, m_err_o}); else pass_cnt++;
            tick();
        end
        #4;
        total_cnt++; if ({s_cyc_o, s_stb_o, m_err_o} !== 6'b00_0100) $display("FAIL tmo_fire got=%b want=000100", {s_cyc_o, s_stb_o, m_err_o}); else pass_cnt++;
        tick();
        #4;
        total_cnt++; if ({grant_o, s_stb_o, m_err_o} !== 9'b0100_1_0000) $display("FAIL tmo_after got=%b want=010010000", {grant_o, s_stb_o, m_err_o}); else pass_cnt++;
`else
        for (int i = 1; i <= 100; i++) begin
            #4;
            total_cnt++; if ({s_stb_o, m_err_o} !== 5'b1_0000) $display("FAIL hang_noerr[%0d] got=%b want=10000", i, {s_stb_o, m_err_o}); else pass_cnt++;
            tick();
        end
`endif
        set_master(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        #4;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL tmo_release got=%b want=0", busy_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_error();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
